mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Sequential arbiter that shares the single-ported RAM between the icache and the dcache. It grants one requester per transaction and drives the RAM from the granted side. It returns data and wait to that side only. Dcache requests have priority; a starvation counter guarantees instruction-fetch forward progress. It sits between the two caches and the RAM model/controller.

Parameters:
STARVE_MAX, 4, consecutive dcache transactions completed while iREN is held before icache is forced ahead (1..15)
WORD_W, 32, data/address width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  icache read request
iaddr  in  WORD_W  icache word address
iload  out  WORD_W  icache read data
iwait  out  1  icache stall; 0 only in the completing cycle
dREN  in  1  dcache read request
dWEN  in  1  dcache write request (wins over dREN if both)
daddr  in  WORD_W  dcache address
dstore  in  WORD_W  dcache write data
dload  out  WORD_W  dcache read data
dwait  out  1  dcache stall; 0 only in the completing cycle
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- Clock CLK, reset nRST asynchronous active-low (fixed).
- Reset: state IDLE, starve_cnt 0. Outputs in IDLE: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
- States: IDLE, IGRANT, DGRANT (registered). RAM-side outputs and waits are combinational from state and inputs.
- IDLE arbitration, decided at the clock edge:
  - If iREN and starve_cnt==STARVE_MAX, go to IGRANT.
  - Else if dREN|dWEN, go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else stay in IDLE.
  - Arbitration costs exactly 1 cycle. No RAM enable is asserted in IDLE.
- IGRANT:
  - Drive ramREN=1, ramaddr=iaddr, iload=ramload.
  - When ramstate==ACCESS: iwait=0 for that cycle, then go to IDLE.
  - BUSY, FREE and ERROR all hold the state with iwait=1. ERROR is retried, not reported.
- DGRANT:
  - Drive ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore, dload=ramload.
  - When ramstate==ACCESS: dwait=0 for that cycle, then go to IDLE.
  - The non-granted side always sees wait=1 and load=0.
- Request withdrawn while granted (iREN low in IGRANT, or dREN|dWEN low in DGRANT):
  - Drop the RAM enables that cycle and return to IDLE.
  - No completion is signalled and starve_cnt is unchanged.
- Back-to-back transactions from the same requester (e.g. two-word block load or writeback) each pay the 1-cycle IDLE gap. The requester's address may change in the cycle after its wait falls.
- starve_cnt, 4-bit:
  - On DGRANT completion with iREN=1: increment, saturating at STARVE_MAX.
  - On IGRANT completion: clear to 0.
  - In IDLE with iREN=0: clear to 0.
  - Otherwise hold.
- Simultaneous first requests (iREN and dREN in IDLE, starve_cnt<STARVE_MAX): dcache is granted.
- dWEN and dREN both high: treated as a write, ramREN=0.
- Reset asserted mid-transaction: immediate return to IDLE, RAM enables drop asynchronously, counter cleared.
- Never assert ramREN and ramWEN together. Never deassert both waits in the same cycle.

Test Plan:
- Reset, then iREN=1 iaddr=0x40 with ramstate BUSY 2 cycles then ACCESS and ramload=0xDEADBEEF -> ramREN from cycle 1; iwait=0 and iload=0xDEADBEEF in the ACCESS cycle only; state back to IDLE next cycle.
- iREN and dWEN raised together, daddr=0x3100, dstore=0x5 -> DGRANT first with ramWEN=1, ramaddr=0x3100, ramstore=5, iwait=1 throughout; IGRANT follows after dwait pulse + 1 IDLE cycle.
- iREN held, dcache issues 6 back-to-back reads, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D; starve_cnt reaches 4 then clears after the I completion.
- DGRANT with ramstate=ERROR 3 cycles then ACCESS -> dwait stays 1 during ERROR, request held, completes on ACCESS.
- dREN dropped mid-DGRANT -> ramREN=0 same cycle, IDLE next, no dwait pulse, starve_cnt unchanged.
- nRST pulsed low during IGRANT -> ramREN=0 immediately, iwait=1, starve_cnt=0, state IDLE after release.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-ported RAM between icache and dcache; dcache
//            has priority, a starvation counter guarantees fetch progress.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int WORD_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam logic [1:0] c_RAM_ACCESS = 2'd2;
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_starve_cnt;

    logic w_dreq;
    logic w_access;
    logic w_starved;

    assign w_dreq    = dREN | dWEN;
    assign w_access  = (ramstate == c_RAM_ACCESS);
    assign w_starved = (r_starve_cnt >= c_STARVE_MAX);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_starve_cnt <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!iREN)
                        r_starve_cnt <= 4'd0;
                    if (iREN && w_starved)
                        r_state <= IGRANT;
                    else if (w_dreq)
                        r_state <= DGRANT;
                    else if (iREN)
                        r_state <= IGRANT;
                end
                IGRANT: begin
                    if (!iREN) begin
                        r_state <= IDLE;
                    end else if (w_access) begin
                        r_state      <= IDLE;
                        r_starve_cnt <= 4'd0;
                    end
                end
                DGRANT: begin
                    if (!w_dreq) begin
                        r_state <= IDLE;
                    end else if (w_access) begin
                        r_state <= IDLE;
                        // Count only dcache wins that actually delayed a fetch
                        if (iREN && !w_starved)
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (r_state)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
                iwait   = ~(iREN & w_access);
            end
            DGRANT: begin
                // A write wins over a simultaneous read request
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                dwait    = ~(w_dreq & w_access);
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed, self-checking bench for mem_arbiter with a
//            transaction-level ownership model checked every cycle.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int c_STARVE_MAX = 4;
    localparam int c_W          = 32;
    localparam logic [1:0] c_FREE   = 2'd0;
    localparam logic [1:0] c_BUSY   = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_ERROR  = 2'd3;

    logic           CLK;
    logic           nRST;
    logic           iREN;
    logic [c_W-1:0] iaddr;
    logic [c_W-1:0] iload;
    logic           iwait;
    logic           dREN;
    logic           dWEN;
    logic [c_W-1:0] daddr;
    logic [c_W-1:0] dstore;
    logic [c_W-1:0] dload;
    logic           dwait;
    logic           ramREN;
    logic           ramWEN;
    logic [c_W-1:0] ramaddr;
    logic [c_W-1:0] ramstore;
    logic [c_W-1:0] ramload;
    logic [1:0]     ramstate;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(.STARVE_MAX(c_STARVE_MAX), .WORD_W(c_W)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Who currently owns the RAM: 0 nobody, 1 icache, 2 dcache
    int m_owner;
    int m_starve;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_owner  <= 0;
            m_starve <= 0;
        end else begin
            if (m_owner == 0) begin
                if (!iREN) m_starve <= 0;
                if (iREN && m_starve == c_STARVE_MAX) m_owner <= 1;
                else if (dREN || dWEN)                m_owner <= 2;
                else if (iREN)                        m_owner <= 1;
            end else if (m_owner == 1) begin
                if (!iREN) m_owner <= 0;
                else if (ramstate == c_ACCESS) begin
                    m_owner  <= 0;
                    m_starve <= 0;
                end
            end else begin
                if (!(dREN || dWEN)) m_owner <= 0;
                else if (ramstate == c_ACCESS) begin
                    m_owner <= 0;
                    if (iREN) m_starve <= (m_starve + 1 > c_STARVE_MAX) ? c_STARVE_MAX : m_starve + 1;
                end
            end
        end
    end

    // Every-cycle comparison against the ownership model
    always @(negedge CLK) begin : cmp
        logic           e_ren, e_wen, e_iw, e_dw;
        logic [c_W-1:0] e_addr, e_store, e_il, e_dl;
        logic           acc;
        acc     = (ramstate == c_ACCESS);
        e_ren   = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
        e_addr  = '0;   e_store = '0; e_il = '0;   e_dl = '0;
        if (m_owner == 1) begin
            e_ren  = iREN;
            e_addr = iaddr;
            e_il   = ramload;
            e_iw   = !(iREN && acc);
        end else if (m_owner == 2) begin
            e_wen   = dWEN;
            e_ren   = dREN && !dWEN;
            e_addr  = daddr;
            e_store = dstore;
            e_dl    = ramload;
            e_dw    = !((dREN || dWEN) && acc);
        end
        check("m_ramREN",   {31'd0, ramREN}, {31'd0, e_ren});
        check("m_ramWEN",   {31'd0, ramWEN}, {31'd0, e_wen});
        check("m_ramaddr",  ramaddr,  e_addr);
        check("m_ramstore", ramstore, e_store);
        check("m_iload",    iload,    e_il);
        check("m_dload",    dload,    e_dl);
        check("m_iwait",    {31'd0, iwait}, {31'd0, e_iw});
        check("m_dwait",    {31'd0, dwait}, {31'd0, e_dw});
        check("m_starve",   {28'd0, dut.r_starve_cnt}, 32'(m_starve));
        check("m_en_excl",  {31'd0, ramREN & ramWEN}, 32'd0);
        check("m_wait_excl", {31'd0, ~iwait & ~dwait}, 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    string glog;
    int    dn;
    int    maxcnt;
    logic  found;

    initial begin
        nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = c_FREE;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_ramREN", {31'd0, ramREN}, 32'd0);
        check("rst_iwait",  {31'd0, iwait},  32'd1);
        check("rst_dwait",  {31'd0, dwait},  32'd1);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_cnt", {28'd0, dut.r_starve_cnt}, 32'd0);

        // Single icache fetch, two BUSY cycles then ACCESS
        tick();
        nRST = 1'b1; iREN = 1'b1; iaddr = 32'h40; ramstate = c_BUSY;
        @(negedge CLK); check("t1_arb_ren", {31'd0, ramREN}, 32'd0);
        tick();
        @(negedge CLK); check("t1_ren", {31'd0, ramREN}, 32'd1);
        check("t1_addr", ramaddr, 32'h40);
        check("t1_busy_iwait", {31'd0, iwait}, 32'd1);
        tick();
        @(negedge CLK); check("t1_busy2_iwait", {31'd0, iwait}, 32'd1);
        tick();
        ramstate = c_ACCESS; ramload = 32'hDEADBEEF;
        @(negedge CLK); check("t1_iwait", {31'd0, iwait}, 32'd0);
        check("t1_iload", iload, 32'hDEADBEEF);
        check("t1_dwait", {31'd0, dwait}, 32'd1);
        tick();
        iREN = 1'b0; ramstate = c_FREE;
        @(negedge CLK); check("t1_idle_ren", {31'd0, ramREN}, 32'd0);
        check("t1_idle_iwait", {31'd0, iwait}, 32'd1);

        // Simultaneous icache read and dcache write (dREN also high)
        tick();
        iREN = 1'b1; dWEN = 1'b1; dREN = 1'b1; daddr = 32'h3100; dstore = 32'h5;
        ramstate = c_ACCESS;
        @(negedge CLK); check("t2_arb_wen", {31'd0, ramWEN}, 32'd0);
        tick();
        @(negedge CLK); check("t2_wen", {31'd0, ramWEN}, 32'd1);
        check("t2_ren", {31'd0, ramREN}, 32'd0);
        check("t2_addr", ramaddr, 32'h3100);
        check("t2_store", ramstore, 32'h5);
        check("t2_dwait", {31'd0, dwait}, 32'd0);
        check("t2_iwait", {31'd0, iwait}, 32'd1);
        tick();
        dWEN = 1'b0; dREN = 1'b0;
        @(negedge CLK); check("t2_gap_iwait", {31'd0, iwait}, 32'd1);
        check("t2_gap_ren", {31'd0, ramREN}, 32'd0);
        tick();
        @(negedge CLK); check("t2_i_ren", {31'd0, ramREN}, 32'd1);
        check("t2_i_iwait", {31'd0, iwait}, 32'd0);
        tick();
        iREN = 1'b0;

        // Starvation: icache held while dcache issues six reads
        tick();
        ramstate = c_ACCESS; iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h200;
        glog = ""; dn = 0; maxcnt = 0;
        for (int c = 0; c < 60 && dn < 6; c++) begin
            @(negedge CLK);
            if (!dwait) begin glog = {glog, "D"}; dn++; end
            if (!iwait) glog = {glog, "I"};
            if (int'(dut.r_starve_cnt) > maxcnt) maxcnt = int'(dut.r_starve_cnt);
        end
        tick();
        dREN = 1'b0; iREN = 1'b0;
        check("t3_dcount", 32'(dn), 32'd6);
        check("t3_maxcnt", 32'(maxcnt), 32'd4);
        n_vec++;
        if (glog != "DDDDIDD") begin
            n_err++;
            $display("FAIL t3_order: got %s, expected DDDDIDD", glog);
        end

        // ERROR is retried until ACCESS
        tick();
        daddr = 32'h80; dREN = 1'b1; ramstate = c_ERROR;
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("t4_err_dwait", {31'd0, dwait}, 32'd1);
            check("t4_err_ren", {31'd0, ramREN}, 32'd1);
            tick();
        end
        ramstate = c_ACCESS; ramload = 32'h12345678;
        @(negedge CLK); check("t4_dwait", {31'd0, dwait}, 32'd0);
        check("t4_dload", dload, 32'h12345678);
        check("t4_iload", iload, 32'd0);
        tick();
        dREN = 1'b0; ramstate = c_FREE;

        // dcache request withdrawn mid-grant, counter preserved
        tick();
        iREN = 1'b1; dREN = 1'b1; daddr = 32'h90; ramstate = c_ACCESS;
        tick();
        @(negedge CLK); check("t5_first_dwait", {31'd0, dwait}, 32'd0);
        tick();
        ramstate = c_BUSY;
        @(negedge CLK); check("t5_cnt_before", {28'd0, dut.r_starve_cnt}, 32'd1);
        tick();
        dREN = 1'b0;
        @(negedge CLK); check("t5_wd_ren", {31'd0, ramREN}, 32'd0);
        check("t5_wd_dwait", {31'd0, dwait}, 32'd1);
        tick();
        @(negedge CLK); check("t5_cnt_after", {28'd0, dut.r_starve_cnt}, 32'd1);

        // Reset pulse during an icache grant
        found = 1'b0;
        for (int c = 0; c < 5 && !found; c++) begin
            @(negedge CLK);
            found = ramREN;
        end
        check("t6_igrant_seen", {31'd0, found}, 32'd1);
        #2 nRST = 1'b0;
        #1;
        check("t6_rst_ren", {31'd0, ramREN}, 32'd0);
        check("t6_rst_iwait", {31'd0, iwait}, 32'd1);
        check("t6_rst_cnt", {28'd0, dut.r_starve_cnt}, 32'd0);
        tick();
        nRST = 1'b1;
        @(negedge CLK); check("t6_idle_ren", {31'd0, ramREN}, 32'd0);
        tick();
        iREN = 1'b0;
        @(negedge CLK); check("t6_wd_ren", {31'd0, ramREN}, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
